// File: rtl/efpga_xif_pkg.sv
// efpga_xif_pkg: shared types and constants for the eFPGA link controller.
// FSM state encodings, default widths and the result-slice helper.
package efpga_xif_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned N_RES_DEF   = 3;
  localparam int unsigned OP_W_DEF    = 2;
  localparam int unsigned DELAY_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TO_DEF      = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Low bit index of result word k in a packed result bus.
  function automatic int unsigned res_lo(
    input int unsigned k,
    input int unsigned w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/efpga_delay_cnt.sv
// efpga_delay_cnt: loadable down-counter that saturates at zero.
// Used for the minimum-latency count and, optionally, the WAIT watchdog.
module efpga_delay_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/efpga_xif_ctrl.sv
// efpga_xif_ctrl: one-op-at-a-time eFPGA coprocessor controller.
// Optional WAIT watchdog enabled by defining EFPGA_TIMEOUT_EN.
module efpga_xif_ctrl
  import efpga_xif_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned N_RES          = N_RES_DEF,
  parameter int unsigned OP_W           = OP_W_DEF,
  parameter int unsigned DELAY_W        = DELAY_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TO_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [OP_W-1:0]         req_operator_i,
  input  logic [DATA_W-1:0]       req_operand_a_i,
  input  logic [DATA_W-1:0]       req_operand_b_i,
  input  logic [DELAY_W-1:0]      req_delay_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [N_RES*DATA_W-1:0] rsp_result_o,
  output logic                    rsp_timeout_o,
  output logic                    eFPGA_en_o,
  output logic                    eFPGA_write_strobe_o,
  output logic [OP_W-1:0]         eFPGA_operator_o,
  output logic [DATA_W-1:0]       eFPGA_operand_a_o,
  output logic [DATA_W-1:0]       eFPGA_operand_b_o,
  output logic [DELAY_W-1:0]      eFPGA_delay_o,
  input  logic [N_RES*DATA_W-1:0] eFPGA_result_i,
  input  logic                    eFPGA_fpga_done_i,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        op_count_o
);

  localparam int unsigned RW = N_RES * DATA_W;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DELAY_W-1:0]  dly_q;
  logic [RW-1:0]       res_q, cap_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DELAY_W-1:0]  dly_cnt;
  logic                dly_zero;
  logic                accept, in_wait;
  logic                complete, timeout;

  assign accept   = (state_q == ST_IDLE) && req_valid_i;
  assign in_wait  = (state_q == ST_WAIT);
  assign complete = in_wait && eFPGA_fpga_done_i && dly_zero;

  efpga_delay_cnt #(
    .W(DELAY_W)
  ) u_dly (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_val_i (req_delay_i),
    .dec_i      (in_wait),
    .cnt_o      (dly_cnt),
    .zero_o     (dly_zero)
  );

`ifdef EFPGA_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_zero;
  logic            to_q;

  // Loaded with N-1 so it reaches zero in the N-th WAIT cycle.
  efpga_delay_cnt #(
    .W(WD_W)
  ) u_wd (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_val_i (WD_W'(TIMEOUT_CYCLES - 1)),
    .dec_i      (in_wait),
    .cnt_o      (wd_cnt),
    .zero_o     (wd_zero)
  );

  assign timeout = in_wait && wd_zero && !complete;

  // Timeout flag lives for the RESP phase only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q <= 1'b0;
    end else if (timeout) begin
      to_q <= 1'b1;
    end else if ((state_q == ST_RESP) && rsp_ready_i) begin
      to_q <= 1'b0;
    end
  end

  assign rsp_timeout_o = to_q;
`else
  assign timeout       = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid_i) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (complete || timeout) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Word-wise copy of the eFPGA result bus.
  always_comb begin
    cap_d = '0;
    for (int unsigned k = 0; k < N_RES; k++) begin
      cap_d[res_lo(k, DATA_W) +: DATA_W] =
        eFPGA_result_i[res_lo(k, DATA_W) +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Operand registers hold until the next accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dly_q <= '0;
    end else if (accept) begin
      op_q  <= req_operator_i;
      a_q   <= req_operand_a_i;
      b_q   <= req_operand_b_i;
      dly_q <= req_delay_i;
    end
  end

  // Result capture and completed-operation count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (complete)     res_q <= cap_d;
      else if (timeout) res_q <= '0;
      if (complete || timeout) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign req_ready_o          = (state_q == ST_IDLE);
  assign rsp_valid_o          = (state_q == ST_RESP);
  assign busy_o               = (state_q != ST_IDLE);
  assign eFPGA_write_strobe_o = (state_q == ST_ISSUE);
  assign eFPGA_en_o           = (state_q == ST_ISSUE) || in_wait;
  assign eFPGA_operator_o     = op_q;
  assign eFPGA_operand_a_o    = a_q;
  assign eFPGA_operand_b_o    = b_q;
  assign eFPGA_delay_o        = dly_q;
  assign rsp_result_o         = res_q;
  assign op_count_o           = cnt_q;

endmodule

// File: tb/tb_efpga_xif_ctrl.sv
// tb_efpga_xif_ctrl: table-driven bench with result scoreboard.
// Define EFPGA_TIMEOUT_EN for both RTL and bench to cover the watchdog.
module tb_efpga_xif_ctrl;

  localparam int DW = 32;
  localparam int NR = 3;
  localparam int RW = DW * NR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [3:0]    req_dly;
  logic          rsp_valid, rsp_ready, rsp_to;
  logic [RW-1:0] rsp_res;
  logic          en, strobe;
  logic [1:0]    f_op;
  logic [DW-1:0] f_a, f_b;
  logic [3:0]    f_dly;
  logic [RW-1:0] f_res;
  logic          f_done;
  logic          busy;
  logic [15:0]   op_cnt;

  always #5 clk = ~clk;

  efpga_xif_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .req_valid_i          (req_valid),
    .req_ready_o          (req_ready),
    .req_operator_i       (req_op),
    .req_operand_a_i      (req_a),
    .req_operand_b_i      (req_b),
    .req_delay_i          (req_dly),
    .rsp_valid_o          (rsp_valid),
    .rsp_ready_i          (rsp_ready),
    .rsp_result_o         (rsp_res),
    .rsp_timeout_o        (rsp_to),
    .eFPGA_en_o           (en),
    .eFPGA_write_strobe_o (strobe),
    .eFPGA_operator_o     (f_op),
    .eFPGA_operand_a_o    (f_a),
    .eFPGA_operand_b_o    (f_b),
    .eFPGA_delay_o        (f_dly),
    .eFPGA_result_i       (f_res),
    .eFPGA_fpga_done_i    (f_done),
    .busy_o               (busy),
    .op_count_o           (op_cnt)
  );

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    dly;
    int            done_at;
    logic [RW-1:0] res;
    int            bp;
    int            exp_lat;
    logic          exp_to;
  } vec_t;

  typedef struct {
    logic [RW-1:0] res;
    logic          to;
    logic [15:0]   cnt;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] ops = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] op, input logic [DW-1:0] a,
    input logic [DW-1:0] b, input logic [3:0] dly,
    input int done_at, input logic [RW-1:0] res,
    input int bp, input int lat, input logic to);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.dly = dly;
    v.done_at = done_at; v.res = res; v.bp = bp;
    v.exp_lat = lat; v.exp_to = to;
    return v;
  endfunction

  task automatic idle_outs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_strobe"}, strobe, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_to"}, rsp_to, 0);
    chk({tag, "_opa"}, f_a, 0);
    chk({tag, "_oper"}, f_op, 0);
    chk({tag, "_dly"}, f_dly, 0);
    chk({tag, "_res"}, rsp_res, 0);
    chk({tag, "_cnt"}, op_cnt, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int            since;
    bit            seen;
    logic [RW-1:0] held;
    sb_t           e;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_dly   = v.dly;
    f_res     = v.res;
    f_done    = (v.done_at == 0);
    @(posedge clk);
    e.res = v.exp_to ? '0 : v.res;
    e.to  = v.exp_to;
    e.cnt = ops + 16'd1;
    sb.push_back(e);
    ops = ops + 16'd1;
    seen = 1'b0;
    since = 0;
    while (!seen && since < 60) begin
      @(negedge clk);
      since++;
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        chk("strobe", strobe, since == 1);
        chk("en_active", en, 1);
        if (since == 1) begin
          chk("f_op", f_op, v.op);
          chk("f_a", f_a, v.a);
          chk("f_b", f_b, v.b);
          chk("f_dly", f_dly, v.dly);
        end
        f_done = (v.done_at == 0) ||
                 (since >= 2 + v.done_at);
      end
    end
    if (!seen) begin
      chk("rsp_wait_bound", 0, 1);
      return;
    end
    chk("latency", since, v.exp_lat);
    chk("en_resp", en, 0);
    chk("ready_resp", req_ready, 0);
    chk("busy_resp", busy, 1);
    held = rsp_res;
    for (int i = 0; i < v.bp; i++) begin
      f_res  = {$urandom, $urandom, $urandom};
      f_done = $urandom_range(0, 1);
      @(negedge clk);
      chk("bp_stable", rsp_res, held);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("result", rsp_res, e.res);
      chk("timeout", rsp_to, e.to);
      chk("op_count", op_cnt, e.cnt);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    f_done    = 1'b0;
    chk("post_rspv", rsp_valid, 0);
    chk("post_ready", req_ready, 1);
    chk("post_to", rsp_to, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_dly   = '0;
    rsp_ready = 1'b0;
    f_res     = '0;
    f_done    = 1'b0;
    repeat (3) @(negedge clk);
    idle_outs("rst");
    rst_n = 1'b1;

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_a     = 32'h55;
    req_dly   = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_en", en, 1);
    #2 rst_n = 1'b0;
    #1 idle_outs("async");
    @(negedge clk);
    rst_n  = 1'b1;
    f_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("norsp_after_rst", rsp_valid, 0);
    end
    f_done = 1'b0;

    tbl.push_back(mk(2'b01, 32'h5, 32'h3, 4'd0, 0,
      {32'h0, 32'h0, 32'h8}, 0, 3, 1'b0));
    tbl.push_back(mk(2'b10, 32'h11, 32'h22, 4'd4, 0,
      {32'h3, 32'h2, 32'h1}, 0, 7, 1'b0));
    tbl.push_back(mk(2'b00, 32'hCAFE, 32'hF00D, 4'd0, 10,
      {32'hA5A5_A5A5, 32'h1234_5678, 32'hDEAD_BEEF},
      0, 13, 1'b0));
    tbl.push_back(mk(2'b11, 32'h7, 32'h9, 4'd0, 0,
      {32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003},
      5, 3, 1'b0));
    tbl.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'h0, 4'd15, 3,
      {32'h111, 32'h222, 32'h333}, 1, 18, 1'b0));
    tbl.push_back(mk(2'b10, 32'h8000_0000, 32'h1, 4'd2, 6,
      {32'h444, 32'h555, 32'h666}, 2, 9, 1'b0));
`ifdef EFPGA_TIMEOUT_EN
    tbl.push_back(mk(2'b01, 32'h1, 32'h2, 4'd0, 1000,
      {32'h777, 32'h888, 32'h999}, 2, 18, 1'b1));
    tbl.push_back(mk(2'b10, 32'h3, 32'h4, 4'd0, 15,
      {32'hAAA, 32'hBBB, 32'hCCC}, 0, 18, 1'b0));
`endif

    foreach (tbl[i]) run_vec(tbl[i]);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/efpga_xif_ctrl.md
Name: efpga_xif_ctrl

Overview:
Parametrised eFPGA coprocessor controller; next-generation replacement for the fixed 32-bit, 3-result, 2-bit-operator eFPGA link of forte_soc_top. Accepts one operation from the core over a valid/ready request channel. Drives the eFPGA operand, operator and strobe lines, then waits for done and a programmable minimum delay. Captures N result words and returns them over a valid/ready response channel.

Parameters:
DATA_W, 32, operand/result word width
N_RES, 3, number of eFPGA result words (1..4)
OP_W, 2, operator field width
DELAY_W, 4, minimum-latency field width
CNT_W, 16, completed-operation counter width
TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with EFPGA_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  operation request valid
req_ready_o  out  1  controller can accept a request
req_operator_i  in  OP_W  operator code
req_operand_a_i  in  DATA_W  operand A
req_operand_b_i  in  DATA_W  operand B
req_delay_i  in  DELAY_W  minimum cycles in WAIT before completion
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  core accepts result
rsp_result_o  out  N_RES*DATA_W  captured results; word k at [k*DATA_W +: DATA_W]
rsp_timeout_o  out  1  response ended by watchdog
eFPGA_en_o  out  1  eFPGA enable
eFPGA_write_strobe_o  out  1  one-cycle operand-load strobe
eFPGA_operator_o  out  OP_W  registered operator
eFPGA_operand_a_o  out  DATA_W  registered operand A
eFPGA_operand_b_o  out  DATA_W  registered operand B
eFPGA_delay_o  out  DELAY_W  registered delay field
eFPGA_result_i  in  N_RES*DATA_W  eFPGA results
eFPGA_fpga_done_i  in  1  eFPGA done, level-sensitive
busy_o  out  1  state != IDLE
op_count_o  out  CNT_W  completed operations, wraps

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. All outputs 0, except req_ready_o=1. Registers, counter and results cleared. Reset mid-operation abandons the operation; no response issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch operator, operands and delay into the eFPGA_* output registers (visible next cycle); load delay counter = req_delay_i; go to ISSUE.
- ISSUE (exactly 1 cycle): eFPGA_write_strobe_o=1, eFPGA_en_o=1. eFPGA_fpga_done_i ignored. Go to WAIT.
- WAIT: eFPGA_en_o=1. Delay counter decrements each cycle, saturating at 0.
- WAIT completion: completes in the first cycle with eFPGA_fpga_done_i=1 AND counter==0. On that edge, capture eFPGA_result_i into rsp_result_o, increment op_count_o (modulo 2^CNT_W), go to RESP.
- Latency: delay=0 and done already high gives request handshake to rsp_valid_o in 3 cycles. delay=D with done high adds D cycles.
- RESP: rsp_valid_o=1; eFPGA_en_o=0; rsp_result_o held stable. On rsp_ready_i go to IDLE. No new request is accepted in the same cycle.
- Backpressure: rsp_valid_o stays high and data stays stable until accepted. eFPGA operand outputs hold their last values until the next request.
- Throughput: at most one operation per 4 cycles. No queueing.
- op_count_o counts both normal and timeout completions.

Optional Feature:
- Macro: EFPGA_TIMEOUT_EN.
- Defined: a watchdog counts WAIT cycles. After TIMEOUT_CYCLES cycles in WAIT without completion, go to RESP with rsp_timeout_o=1 and rsp_result_o all zeros. rsp_timeout_o clears on leaving RESP. If completion and timeout fall in the same cycle, completion wins and rsp_timeout_o=0.
- Undefined: WAIT lasts indefinitely, rsp_timeout_o is tied 0, and no watchdog logic is present.

Decomposition:
- Package efpga_xif_pkg: FSM state enum, default width constants, result-slice helper function.
- One sub-module, efpga_delay_cnt: loadable down-counter saturating at 0, with zero flag. The watchdog reuses it with a TIMEOUT_CYCLES load.

Test Plan:
- Reset then idle: rst_ni=0 mid-WAIT -> all outputs 0, req_ready_o=1, no rsp_valid_o after release.
- Basic op: op=2'b01, A=0x0000_0005, B=0x0000_0003, delay=0, done held 1, result[0]=0x8 -> write_strobe 1 cycle, rsp_valid_o 3 cycles after handshake, word0=0x8, op_count_o=1.
- Minimum delay: delay=4, done high from ISSUE -> completion exactly 4 cycles later than the delay=0 case.
- Late done: delay=0, done rises 10 cycles into WAIT, results 0xDEAD_BEEF/0x1234_5678/0xA5A5_A5A5 -> captured values match; eFPGA_en_o high for ISSUE plus all WAIT cycles.
- Backpressure: rsp_ready_i low for 5 cycles while eFPGA_result_i changes -> rsp_result_o stable; req_ready_o=0 until acceptance.
- Timeout (EFPGA_TIMEOUT_EN, TIMEOUT_CYCLES=16): done never asserted -> rsp_valid_o after 16 WAIT cycles, rsp_timeout_o=1, results 0. Second run with done asserted on cycle 16 -> rsp_timeout_o=0.
